ddr4_dram_responder: RTL and testbench

- Behavioural-synthesizable DDR4 DRAM-side responder: the memory end of the controller's command/data interface on ddr_intf.
- Decodes DDR4 commands (ACT/PRE/PREA/RD/WR/REF), tracks per-bank open rows and stores write bursts in a local array.
- Returns read bursts after CL; flags protocol violations.
- Instantiated in the bench opposite the controller so tests run closed-loop without an external vendor model.

---
 rtl/ddr4_dram_responder.sv | 196 +++++++++++++++++++
 tb/tb_ddr4_dram_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_dram_responder.sv
// DRAM-side DDR4 responder: decodes commands, tracks open rows, stores write bursts
// in a local array, replays read bursts after CL and reports protocol violations.
module ddr4_dram_responder #(
    parameter int DQ_W = 64,
    parameter int CL   = 16,
    parameter int CWL  = 12,
    parameter int BL   = 8
) (
    input  logic            CK_t,
    input  logic            reset,
    input  logic            cs_n,
    input  logic            act_n,
    input  logic            ras_n,
    input  logic            cas_n,
    input  logic            we_n,
    input  logic [1:0]      bg,
    input  logic [1:0]      ba,
    input  logic [13:0]     addr,
    input  logic [DQ_W-1:0] wr_dq,
    input  logic            wr_dq_valid,
    output logic [DQ_W-1:0] rd_dq,
    output logic            rd_valid,
    output logic [15:0]     bank_open,
    output logic            err_pulse,
    output logic [2:0]      err_code,
    output logic [7:0]      err_count
);

    localparam int                GAP_W   = $clog2(BL + 1);
    localparam logic [GAP_W-1:0]  GAP_RDY = GAP_W'(BL);

    typedef struct packed {
        logic        vld;
        logic [15:0] base;
    } burst_t;

    logic [15:0]     bank_open_q, bank_open_d;
    logic [16:0]     bank_row_q [16];
    burst_t          rd_pipe_q [CL];
    burst_t          wr_pipe_q [CWL];
    logic [DQ_W-1:0] mem [65536];

    logic [15:0]      rd_base_q, wr_base_q;
    logic [2:0]       rd_k_q, wr_k_q;
    logic [3:0]       rd_cnt_q, wr_cnt_q;
    logic [GAP_W-1:0] rd_gap_q, wr_gap_q;

    logic [DQ_W-1:0] rd_dq_q;
    logic            rd_valid_q;
    logic            err_pulse_q;
    logic [2:0]      err_code_q, err_code_d;
    logic [7:0]      err_count_q;

    logic [2:0]  cmd;
    logic        sel, is_act, is_pre, is_prea, is_rd, is_wr, is_ref;
    logic [3:0]  cmd_bank;
    logic [16:0] row_act, cur_row;
    logic        cur_open;
    logic [15:0] cmd_base;
    logic        rd_ok, wr_ok;
    logic        unused_row_bits;

    logic        rd_launch, rd_beat_en, wr_launch, wr_win, wr_we;
    logic [2:0]  rd_beat, wr_beat;
    logic [15:0] rd_addr, wr_addr;
    logic [6:1]  err_v;

    always_comb begin
        cmd      = {ras_n, cas_n, we_n};
        sel      = !cs_n;
        is_act   = sel && !act_n;
        is_pre   = sel && act_n && (cmd == 3'b010) && !addr[10];
        is_prea  = sel && act_n && (cmd == 3'b010) && addr[10];
        is_rd    = sel && act_n && (cmd == 3'b101);
        is_wr    = sel && act_n && (cmd == 3'b100);
        is_ref   = sel && act_n && (cmd == 3'b001);
        cmd_bank = {bg, ba};
        row_act  = {ras_n, cas_n, we_n, addr};
        cur_open = bank_open_q[cmd_bank];
        cur_row  = bank_row_q[cmd_bank];
        cmd_base = {bg, ba, cur_row[1:0], addr[9:3], addr[2:0]};
        rd_ok    = is_rd && cur_open && (rd_gap_q >= GAP_RDY);
        wr_ok    = is_wr && cur_open && (wr_gap_q >= GAP_RDY);
    end

    // Only row[1:0] reaches the array index; the rest of the row is bookkeeping.
    assign unused_row_bits = ^cur_row[16:2];

    always_comb begin
        bank_open_d = bank_open_q;
        if (is_act && !cur_open) bank_open_d[cmd_bank] = 1'b1;
        if (is_pre)              bank_open_d[cmd_bank] = 1'b0;
        if (is_prea)             bank_open_d = '0;
    end

    // Launch takes the first beat straight from the pipe tail; later beats wrap in the burst.
    always_comb begin
        rd_launch  = rd_pipe_q[CL-1].vld;
        rd_beat_en = rd_launch || (rd_cnt_q != 4'd0);
        rd_beat    = rd_base_q[2:0] + rd_k_q;
        rd_addr    = rd_launch ? rd_pipe_q[CL-1].base : {rd_base_q[15:3], rd_beat};

        wr_launch  = wr_pipe_q[CWL-1].vld;
        wr_win     = wr_launch || (wr_cnt_q != 4'd0);
        wr_beat    = wr_base_q[2:0] + wr_k_q;
        wr_addr    = wr_launch ? wr_pipe_q[CWL-1].base : {wr_base_q[15:3], wr_beat};
        wr_we      = wr_win && wr_dq_valid;
    end

    always_comb begin
        err_v[1] = is_act && cur_open;
        err_v[2] = (is_rd || is_wr) && !cur_open;
        err_v[3] = is_ref && (bank_open_q != 16'd0);
        err_v[4] = wr_win && !wr_dq_valid;
        err_v[5] = !wr_win && wr_dq_valid;
        err_v[6] = (is_rd && (rd_gap_q < GAP_RDY)) || (is_wr && (wr_gap_q < GAP_RDY));
        err_code_d = 3'd0;
        for (int i = 6; i >= 1; i--) begin
            if (err_v[i]) err_code_d = 3'(i);
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            bank_open_q <= '0;
            for (int i = 0; i < 16; i++)  bank_row_q[i] <= '0;
            for (int i = 0; i < CL; i++)  rd_pipe_q[i]  <= '0;
            for (int i = 0; i < CWL; i++) wr_pipe_q[i]  <= '0;
            rd_base_q   <= '0;
            wr_base_q   <= '0;
            rd_k_q      <= '0;
            wr_k_q      <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rd_gap_q    <= GAP_RDY;
            wr_gap_q    <= GAP_RDY;
            rd_dq_q     <= '0;
            rd_valid_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            err_count_q <= '0;
        end else begin
            bank_open_q <= bank_open_d;
            if (is_act && !cur_open) bank_row_q[cmd_bank] <= row_act;

            rd_pipe_q[0] <= burst_t'{vld: rd_ok, base: cmd_base};
            wr_pipe_q[0] <= burst_t'{vld: wr_ok, base: cmd_base};
            for (int i = 1; i < CL; i++)  rd_pipe_q[i] <= rd_pipe_q[i-1];
            for (int i = 1; i < CWL; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];

            if (rd_ok)                   rd_gap_q <= GAP_W'(1);
            else if (rd_gap_q < GAP_RDY) rd_gap_q <= rd_gap_q + GAP_W'(1);
            if (wr_ok)                   wr_gap_q <= GAP_W'(1);
            else if (wr_gap_q < GAP_RDY) wr_gap_q <= wr_gap_q + GAP_W'(1);

            if (rd_launch) begin
                rd_base_q <= rd_pipe_q[CL-1].base;
                rd_k_q    <= 3'd1;
                rd_cnt_q  <= 4'd7;
            end else if (rd_cnt_q != 4'd0) begin
                rd_k_q    <= rd_k_q + 3'd1;
                rd_cnt_q  <= rd_cnt_q - 4'd1;
            end
            rd_valid_q <= rd_beat_en;
            if (rd_beat_en) rd_dq_q <= mem[rd_addr];

            if (wr_launch) begin
                wr_base_q <= wr_pipe_q[CWL-1].base;
                wr_k_q    <= 3'd1;
                wr_cnt_q  <= 4'd7;
            end else if (wr_cnt_q != 4'd0) begin
                wr_k_q    <= wr_k_q + 3'd1;
                wr_cnt_q  <= wr_cnt_q - 4'd1;
            end

            err_pulse_q <= (err_v != 6'd0);
            if (err_v != 6'd0) begin
                err_code_q <= err_code_d;
                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Array survives reset; a read in the same cycle as a write sees the old word.
    always_ff @(posedge CK_t) begin
        if (wr_we) mem[wr_addr] <= wr_dq;
    end

    assign rd_dq     = rd_dq_q;
    assign rd_valid  = rd_valid_q;
    assign bank_open = bank_open_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ddr4_dram_responder.sv
// Directed closed-loop bench for ddr4_dram_responder.
module tb_ddr4_dram_responder;

    localparam int DQ_W = 64;
    localparam int CL   = 16;
    localparam int CWL  = 12;
    localparam int BL   = 8;

    logic            CK_t = 1'b0;
    logic            reset;
    logic            cs_n, act_n, ras_n, cas_n, we_n;
    logic [1:0]      bg, ba;
    logic [13:0]     addr;
    logic [DQ_W-1:0] wr_dq;
    logic            wr_dq_valid;
    logic [DQ_W-1:0] rd_dq;
    logic            rd_valid;
    logic [15:0]     bank_open;
    logic            err_pulse;
    logic [2:0]      err_code;
    logic [7:0]      err_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int mon_cyc[$];
    logic [DQ_W-1:0] mon_dat[$];

    ddr4_dram_responder #(.DQ_W(DQ_W), .CL(CL), .CWL(CWL), .BL(BL)) dut (
        .CK_t(CK_t), .reset(reset), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba), .addr(addr), .wr_dq(wr_dq),
        .wr_dq_valid(wr_dq_valid), .rd_dq(rd_dq), .rd_valid(rd_valid),
        .bank_open(bank_open), .err_pulse(err_pulse), .err_code(err_code),
        .err_count(err_count)
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;
    always @(negedge CK_t) begin
        if (rd_valid === 1'b1) begin
            mon_cyc.push_back(cyc);
            mon_dat.push_back(rd_dq);
        end
    end

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic an, input logic [1:0] g,
                         input logic [1:0] a, input logic [13:0] ad);
        cs_n = 1'b0; act_n = an; {ras_n, cas_n, we_n} = c; bg = g; ba = a; addr = ad;
        tick();
        cs_n = 1'b1; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; addr = '0;
    endtask

    task automatic do_act(input logic [1:0] g, input logic [1:0] a, input logic [16:0] row);
        issue(row[16:14], 1'b0, g, a, row[13:0]);
    endtask

    task automatic do_rd(input logic [1:0] g, input logic [1:0] a, input logic [9:0] col,
                         output int t);
        issue(3'b101, 1'b1, g, a, {4'd0, col});
        t = cyc;
    endtask

    task automatic clear_mon();
        mon_cyc.delete();
        mon_dat.delete();
    endtask

    // errs[j] holds err_pulse observed after edge T+j of the write command at T.
    task automatic wr_burst(input logic [1:0] g, input logic [1:0] a, input logic [9:0] col,
                            input logic [DQ_W-1:0] d0, input logic [7:0] skip,
                            output logic [31:0] errs);
        errs = '0;
        issue(3'b100, 1'b1, g, a, {4'd0, col});
        errs[0] = err_pulse;
        for (int j = 1; j <= CWL + 8; j++) begin
            if (j >= CWL && j < CWL + 8) begin
                wr_dq       = d0 + DQ_W'(j - CWL);
                wr_dq_valid = !skip[j - CWL];
            end else begin
                wr_dq_valid = 1'b0;
            end
            tick();
            errs[j] = err_pulse;
        end
        wr_dq_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs_n = 1'b1; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        bg = '0; ba = '0; addr = '0; wr_dq = '0; wr_dq_valid = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (rd_valid !== 1'b0 || rd_dq !== '0 || bank_open !== 16'h0 || err_pulse !== 1'b0 ||
            err_code !== 3'd0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got rv=%b dq=%h bo=%h ep=%b ec=%0d cnt=%0d, want all zero",
                     rd_valid, rd_dq, bank_open, err_pulse, err_code, err_count);
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_act_wr_rd();
        logic [31:0] errs;
        int t;
        do_act(2'd1, 2'd2, 17'h00123);
        tests_run++;
        if (bank_open !== 16'h0040) begin
            tests_failed++;
            $display("FAIL act_open: got %h, want 0040", bank_open);
        end
        wr_burst(2'd1, 2'd2, 10'h008, 64'hA0, 8'h00, errs);
        tests_run++;
        if (errs !== 32'h0) begin
            tests_failed++;
            $display("FAIL wr_clean_errs: got %h, want 0", errs);
        end
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h008, t);
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_cyc.size() != 8) begin
            tests_failed++;
            $display("FAIL rd_beats: got %0d beats, want 8", mon_cyc.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (mon_cyc[k] != t + CL + k || mon_dat[k] !== 64'hA0 + 64'(k)) begin
                    tests_failed++;
                    $display("FAIL rd_beat%0d: got cyc %0d data %h, want cyc %0d data %h",
                             k, mon_cyc[k], mon_dat[k], t + CL + k, 64'hA0 + 64'(k));
                end
            end
        end
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h00D, t);
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_dat.size() != 8) begin
            tests_failed++;
            $display("FAIL wrap_beats: got %0d beats, want 8", mon_dat.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (mon_dat[k] !== 64'hA0 + 64'((k + 5) % 8)) begin
                    tests_failed++;
                    $display("FAIL wrap_beat%0d: got %h, want %h", k, mon_dat[k],
                             64'hA0 + 64'((k + 5) % 8));
                end
            end
        end
        tests_run++;
        if (err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL no_err_count: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_errors();
        int t;
        clear_mon();
        do_rd(2'd0, 2'd3, 10'h000, t);
        tests_run++;
        if (err_pulse !== 1'b1 || err_code !== 3'd2 || err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL rd_closed: got ep=%b ec=%0d cnt=%0d, want 1 2 1",
                     err_pulse, err_code, err_count);
        end
        tick();
        tests_run++;
        if (err_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_width: got %b, want 0", err_pulse);
        end
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL rd_closed_data: got %0d beats, want 0", mon_cyc.size());
        end
        do_act(2'd1, 2'd2, 17'h00000);
        tests_run++;
        if (err_pulse !== 1'b1 || err_code !== 3'd1 || err_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL act_twice: got ep=%b ec=%0d cnt=%0d, want 1 1 2",
                     err_pulse, err_code, err_count);
        end
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h008, t);
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_dat.size() != 8 || mon_dat[0] !== 64'hA0 || mon_dat[7] !== 64'hA7) begin
            tests_failed++;
            $display("FAIL row_kept: got %0d beats, want 8 beats A0..A7", mon_dat.size());
        end
        issue(3'b010, 1'b1, 2'd1, 2'd2, 14'h0);
        tests_run++;
        if (bank_open !== 16'h0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre: got bo=%h ep=%b, want 0000 0", bank_open, err_pulse);
        end
        issue(3'b010, 1'b1, 2'd1, 2'd2, 14'h0);
        issue(3'b001, 1'b1, 2'd0, 2'd0, 14'h0);
        tests_run++;
        if (err_pulse !== 1'b0 || err_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL pre_closed_ref: got ep=%b cnt=%0d, want 0 2", err_pulse, err_count);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, tx;
        do_act(2'd1, 2'd2, 17'h00123);
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h008, t0);
        repeat (3) tick();
        do_rd(2'd1, 2'd2, 10'h008, tx);
        tests_run++;
        if (err_pulse !== 1'b1 || err_code !== 3'd6 || err_count !== 8'd3) begin
            tests_failed++;
            $display("FAIL tccd_err: got ep=%b ec=%0d cnt=%0d, want 1 6 3",
                     err_pulse, err_code, err_count);
        end
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_cyc.size() != 8 || mon_cyc[0] != t0 + CL || mon_cyc[7] != t0 + CL + 7) begin
            tests_failed++;
            $display("FAIL tccd_beats: got %0d beats, want 8 at %0d..%0d",
                     mon_cyc.size(), t0 + CL, t0 + CL + 7);
        end
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h008, t1);
        repeat (7) tick();
        do_rd(2'd1, 2'd2, 10'h008, tx);
        repeat (CL + 12) tick();
        tests_run++;
        if (mon_cyc.size() != 16) begin
            tests_failed++;
            $display("FAIL b2b_beats: got %0d beats, want 16", mon_cyc.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                tests_run++;
                if (mon_cyc[k] != t1 + CL + k || mon_dat[k] !== 64'hA0 + 64'(k % 8)) begin
                    tests_failed++;
                    $display("FAIL b2b_beat%0d: got cyc %0d data %h, want cyc %0d data %h",
                             k, mon_cyc[k], mon_dat[k], t1 + CL + k, 64'hA0 + 64'(k % 8));
                end
            end
        end
    endtask

    task automatic test_write_errors();
        logic [31:0] errs;
        logic [DQ_W-1:0] exp;
        int t;
        wr_burst(2'd1, 2'd2, 10'h010, 64'hB0, 8'h00, errs);
        wr_burst(2'd1, 2'd2, 10'h010, 64'hC0, 8'h08, errs);
        tests_run++;
        if (errs !== (32'h1 << (CWL + 3)) || err_code !== 3'd4 || err_count !== 8'd4) begin
            tests_failed++;
            $display("FAIL missing_beat: got errs=%h ec=%0d cnt=%0d, want %h 4 4",
                     errs, err_code, err_count, 32'h1 << (CWL + 3));
        end
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h010, t);
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_dat.size() != 8) begin
            tests_failed++;
            $display("FAIL miss_rd_beats: got %0d beats, want 8", mon_dat.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp = (k == 3) ? 64'hB3 : 64'hC0 + 64'(k);
                tests_run++;
                if (mon_dat[k] !== exp) begin
                    tests_failed++;
                    $display("FAIL miss_rd_beat%0d: got %h, want %h", k, mon_dat[k], exp);
                end
            end
        end
        wr_dq_valid = 1'b1;
        tick();
        wr_dq_valid = 1'b0;
        tests_run++;
        if (err_pulse !== 1'b1 || err_code !== 3'd5 || err_count !== 8'd5) begin
            tests_failed++;
            $display("FAIL stray_valid: got ep=%b ec=%0d cnt=%0d, want 1 5 5",
                     err_pulse, err_code, err_count);
        end
        tick();
        wr_dq_valid = 1'b1;
        issue(3'b001, 1'b1, 2'd0, 2'd0, 14'h0);
        wr_dq_valid = 1'b0;
        tests_run++;
        if (err_pulse !== 1'b1 || err_code !== 3'd3 || err_count !== 8'd6) begin
            tests_failed++;
            $display("FAIL dual_err: got ep=%b ec=%0d cnt=%0d, want 1 3 6",
                     err_pulse, err_code, err_count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int t;
        do_rd(2'd1, 2'd2, 10'h008, t);
        repeat (20) tick();
        tests_run++;
        if (rd_valid !== 1'b1 || rd_dq !== 64'hA4) begin
            tests_failed++;
            $display("FAIL mid_beat4: got rv=%b dq=%h, want 1 a4", rd_valid, rd_dq);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (rd_valid !== 1'b0 || bank_open !== 16'h0 || rd_dq !== '0 ||
            err_count !== 8'd0 || err_code !== 3'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got rv=%b bo=%h dq=%h cnt=%0d ec=%0d, want zeros",
                     rd_valid, bank_open, rd_dq, err_count, err_code);
        end
        #1 reset = 1'b0;
        clear_mon();
        repeat (20) tick();
        tests_run++;
        if (mon_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL flush: got %0d beats after reset, want 0", mon_cyc.size());
        end
        do_act(2'd1, 2'd2, 17'h00123);
        clear_mon();
        do_rd(2'd1, 2'd2, 10'h008, t);
        repeat (CL + 10) tick();
        tests_run++;
        if (mon_dat.size() != 8) begin
            tests_failed++;
            $display("FAIL retain_beats: got %0d beats, want 8", mon_dat.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (mon_dat[k] !== 64'hA0 + 64'(k)) begin
                    tests_failed++;
                    $display("FAIL retain_beat%0d: got %h, want %h", k, mon_dat[k],
                             64'hA0 + 64'(k));
                end
            end
        end
    endtask

    task automatic test_saturate();
        repeat (300) issue(3'b001, 1'b1, 2'd0, 2'd0, 14'h0);
        tests_run++;
        if (err_count !== 8'd255 || err_code !== 3'd3) begin
            tests_failed++;
            $display("FAIL saturate: got cnt=%0d ec=%0d, want 255 3", err_count, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_act_wr_rd();
        test_errors();
        test_back_to_back();
        test_write_errors();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
